puf_sequencer: RTL and testbench

PUF_SEQUENCER -- requirements
Module: puf_sequencer

---
 rtl/puf_pkg.sv | 17 +
 rtl/puf_sequencer_if.sv | 29 ++
 rtl/puf_majority3.sv | 15 +
 rtl/puf_sequencer.sv | 130 +++++++++++++
 tb/tb_puf_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/puf_pkg.sv
// Shared types and constants for the PUF challenge/response sequencer.
// Optional build macro PUF_SEQ_MAJORITY_EN (see puf_sequencer.sv).
package puf_pkg;

  localparam int PUF_DATA_W = 64;

  // Wide enough for any practical DATA_W; users slice the low bits.
  localparam logic [255:0] PUF_TIMEOUT_SENTINEL = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_SEND
  } puf_state_t;

endpackage

// File: rtl/puf_sequencer_if.sv
// Bus bundle for the sequencer: UART rx/tx streams, PUF array strobe/response, status.
interface puf_sequencer_if
  import puf_pkg::*;
#(
  parameter int DATA_W = PUF_DATA_W
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] puf_challenge;
  logic              puf_start;
  logic              puf_done;
  logic [DATA_W-1:0] puf_response;
  logic              busy;
  logic              timeout_err;

  modport slave (
    input  rx_data, rx_valid, tx_ready, puf_done, puf_response,
    output rx_ready, tx_data, tx_valid, puf_challenge, puf_start, busy, timeout_err
  );

  modport master (
    output rx_data, rx_valid, tx_ready, puf_done, puf_response,
    input  rx_ready, tx_data, tx_valid, puf_challenge, puf_start, busy, timeout_err
  );
endinterface

// File: rtl/puf_majority3.sv
// Combinational bitwise 2-of-3 vote over three PUF responses.
module puf_majority3 #(
  parameter int W = 64
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  output logic [W-1:0] y_o
);

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    assign y_o[gi] = (a_i[gi] & b_i[gi]) | (a_i[gi] & c_i[gi]) | (b_i[gi] & c_i[gi]);
  end

endmodule

// File: rtl/puf_sequencer.sv
// Accepts a challenge, strobes the PUF, waits (bounded) for the response and returns it.
// Macro PUF_SEQ_MAJORITY_EN: evaluate each challenge 3 times and return the bitwise majority.
module puf_sequencer
  import puf_pkg::*;
#(
  parameter int DATA_W         = PUF_DATA_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  puf_sequencer_if.slave  bus
);

  localparam int                CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_W-1:0] SENTINEL = PUF_TIMEOUT_SENTINEL[DATA_W-1:0];

  puf_state_t        state_q, state_d;
  logic [DATA_W-1:0] chal_q, chal_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              terr_q, terr_d;

`ifdef PUF_SEQ_MAJORITY_EN
  logic [1:0]        eval_q, eval_d;
  logic [DATA_W-1:0] resp0_q, resp0_d;
  logic [DATA_W-1:0] resp1_q, resp1_d;
  logic [DATA_W-1:0] vote;

  // Third response is voted straight from the PUF bus; only two need storage.
  puf_majority3 #(.W(DATA_W)) u_vote (
    .a_i (resp0_q),
    .b_i (resp1_q),
    .c_i (bus.puf_response),
    .y_o (vote)
  );
`endif

  always_comb begin
    state_d   = state_q;
    chal_d    = chal_q;
    tx_data_d = tx_data_q;
    cnt_d     = cnt_q;
    terr_d    = terr_q;
`ifdef PUF_SEQ_MAJORITY_EN
    eval_d    = eval_q;
    resp0_d   = resp0_q;
    resp1_d   = resp1_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.rx_valid) begin
          chal_d  = bus.rx_data;
          state_d = ST_START;
`ifdef PUF_SEQ_MAJORITY_EN
          eval_d  = 2'd0;
`endif
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // puf_done is checked first so a response on the last allowed cycle still counts.
        if (bus.puf_done) begin
`ifdef PUF_SEQ_MAJORITY_EN
          if (eval_q == 2'd2) begin
            tx_data_d = vote;
            state_d   = ST_SEND;
          end else begin
            if (eval_q == 2'd0) resp0_d = bus.puf_response;
            else                resp1_d = bus.puf_response;
            eval_d  = eval_q + 2'd1;
            state_d = ST_START;
          end
`else
          tx_data_d = bus.puf_response;
          state_d   = ST_SEND;
`endif
        end else if (cnt_q == CNT_LAST) begin
          tx_data_d = SENTINEL;
          terr_d    = 1'b1;
          state_d   = ST_SEND;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SEND: begin
        if (bus.tx_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      chal_q    <= '0;
      tx_data_q <= '0;
      cnt_q     <= '0;
      terr_q    <= 1'b0;
`ifdef PUF_SEQ_MAJORITY_EN
      eval_q    <= '0;
      resp0_q   <= '0;
      resp1_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      chal_q    <= chal_d;
      tx_data_q <= tx_data_d;
      cnt_q     <= cnt_d;
      terr_q    <= terr_d;
`ifdef PUF_SEQ_MAJORITY_EN
      eval_q    <= eval_d;
      resp0_q   <= resp0_d;
      resp1_q   <= resp1_d;
`endif
    end
  end

  assign bus.rx_ready      = (state_q == ST_IDLE);
  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.puf_start     = (state_q == ST_START);
  assign bus.tx_valid      = (state_q == ST_SEND);
  assign bus.tx_data       = tx_data_q;
  assign bus.puf_challenge = chal_q;
  assign bus.timeout_err   = terr_q;

endmodule

// File: tb/tb_puf_sequencer.sv
// Directed bench for puf_sequencer; builds in single or majority mode (PUF_SEQ_MAJORITY_EN).
module tb_puf_sequencer;

  localparam int DW = 64;
  localparam int TO = 16;
`ifdef PUF_SEQ_MAJORITY_EN
  localparam int NEV = 3;
`else
  localparam int NEV = 1;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks    = 0;
  int   errors    = 0;
  int   start_cnt = 0;
  int   hs_cnt    = 0;
  logic [DW-1:0] ones = '1;

  always #5 clk = ~clk;

  puf_sequencer_if #(.DATA_W(DW)) bus ();

  puf_sequencer #(.DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always @(posedge clk) begin
    if (bus.puf_start === 1'b1) start_cnt++;
    if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) hs_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    int n;
    bus.rx_data  = w;
    bus.rx_valid = 1'b1;
    n = 0;
    while (bus.rx_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (bus.rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait: rx_ready=%b required 1 within 100 cycles", bus.rx_ready);
    end
    tick();
    bus.rx_valid = 1'b0;
  endtask

  // Called in START; answers with resp after d idle cycles in WAIT.
  task automatic do_eval(input logic [DW-1:0] resp, input int d);
    checks++;
    if (bus.puf_start !== 1'b1) begin
      errors++;
      $display("FAIL puf_start_high: got %b required 1", bus.puf_start);
    end
    tick();
    checks++;
    if (bus.puf_start !== 1'b0) begin
      errors++;
      $display("FAIL puf_start_pulse: got %b required 0", bus.puf_start);
    end
    repeat (d) tick();
    bus.puf_response = resp;
    bus.puf_done     = 1'b1;
    tick();
    bus.puf_done     = 1'b0;
  endtask

  task automatic recv(input logic [DW-1:0] exp, input string name);
    int n;
    n = 0;
    while (bus.tx_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp) begin
      errors++;
      $display("FAIL %s_tx: tx_valid=%b tx_data=%h required 1/%h", name, bus.tx_valid, bus.tx_data, exp);
    end
    $display("tx %s data=%h", name, bus.tx_data);
    bus.tx_ready = 1'b1;
    tick();
    bus.tx_ready = 1'b0;
    checks++;
    if (bus.tx_valid !== 1'b0 || bus.rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_after_hs: tx_valid=%b rx_ready=%b required 0/1", name, bus.tx_valid, bus.rx_ready);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++;
    if (bus.tx_valid !== 1'b0 || bus.puf_start !== 1'b0 || bus.busy !== 1'b0 || bus.timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: tx_valid=%b puf_start=%b busy=%b timeout_err=%b required 0", bus.tx_valid, bus.puf_start, bus.busy, bus.timeout_err);
    end
    checks++;
    if (bus.tx_data !== '0 || bus.puf_challenge !== '0) begin
      errors++;
      $display("FAIL reset_data: tx_data=%h puf_challenge=%h required 0", bus.tx_data, bus.puf_challenge);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_rx_ready: got %b required 1", bus.rx_ready);
    end
  endtask

  task automatic test_basic();
    int s0;
    s0 = start_cnt;
    send_word(64'h0123_4567_89AB_CDEF);
    checks++;
    if (bus.puf_challenge !== 64'h0123_4567_89AB_CDEF || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_challenge: challenge=%h busy=%b required 0123456789abcdef/1", bus.puf_challenge, bus.busy);
    end
    for (int i = 0; i < NEV; i++) do_eval(64'hDEAD_BEEF_0000_FFFF, 5);
    checks++;
    if (bus.puf_challenge !== 64'h0123_4567_89AB_CDEF) begin
      errors++;
      $display("FAIL basic_hold: challenge=%h required 0123456789abcdef", bus.puf_challenge);
    end
    checks++;
    if (start_cnt - s0 !== NEV) begin
      errors++;
      $display("FAIL basic_starts: got %0d required %0d", start_cnt - s0, NEV);
    end
    checks++;
    if (bus.timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_terr: got %b required 0", bus.timeout_err);
    end
    recv(64'hDEAD_BEEF_0000_FFFF, "basic");
  endtask

  task automatic test_latency();
    int lat;
    send_word(64'h5555_0000_5555_0000);
    bus.puf_response = 64'h1234_5678_9ABC_DEF0;
    bus.puf_done     = 1'b1;
    lat = 1;
    while (bus.tx_valid !== 1'b1 && lat < 50) begin
      tick();
      lat++;
    end
    bus.puf_done = 1'b0;
    checks++;
    if (lat !== 2 * NEV + 1) begin
      errors++;
      $display("FAIL latency: got %0d cycles required %0d", lat, 2 * NEV + 1);
    end
    recv(64'h1234_5678_9ABC_DEF0, "latency");
    bus.puf_done = 1'b1;
    repeat (2) tick();
    bus.puf_done = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_in_idle: busy=%b tx_valid=%b required 0/0", bus.busy, bus.tx_valid);
    end
  endtask

  task automatic test_timeout();
    int s0;
    s0 = start_cnt;
    send_word(64'hAAAA_BBBB_CCCC_DDDD);
    tick();
    repeat (TO - 1) tick();
    checks++;
    if (bus.tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: tx_valid=%b required 0", bus.tx_valid);
    end
    tick();
    checks++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== ones || bus.timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_fire: tx_valid=%b tx_data=%h terr=%b required 1/all-ones/1", bus.tx_valid, bus.tx_data, bus.timeout_err);
    end
    checks++;
    if (start_cnt - s0 !== 1) begin
      errors++;
      $display("FAIL timeout_starts: got %0d required 1", start_cnt - s0);
    end
    recv(ones, "timeout");
    send_word(64'h0000_0000_0000_0042);
    for (int i = 0; i < NEV; i++) do_eval(64'h0000_0000_0000_0099, 1);
    recv(64'h0000_0000_0000_0099, "after_timeout");
    checks++;
    if (bus.timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: got %b required 1", bus.timeout_err);
    end
  endtask

  task automatic test_done_on_timeout();
    apply_reset();
    send_word(64'h0F0F_0F0F_0F0F_0F0F);
    for (int i = 0; i < NEV; i++) do_eval(64'h3C3C_3C3C_3C3C_3C3C, TO - 1);
    checks++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 64'h3C3C_3C3C_3C3C_3C3C || bus.timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL done_on_timeout: tx_valid=%b tx_data=%h terr=%b required 1/3c3c3c3c3c3c3c3c/0", bus.tx_valid, bus.tx_data, bus.timeout_err);
    end
    recv(64'h3C3C_3C3C_3C3C_3C3C, "done_on_timeout");
  endtask

  task automatic test_back_to_back();
    send_word(64'h0000_0000_0000_00A1);
    for (int i = 0; i < NEV; i++) do_eval(64'h0000_0000_0000_0A1A, 2);
    bus.rx_data  = 64'h0000_0000_0000_00B2;
    bus.rx_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 64'h0000_0000_0000_0A1A || bus.rx_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold c%0d: tx_valid=%b tx_data=%h rx_ready=%b required 1/a1a/0", c, bus.tx_valid, bus.tx_data, bus.rx_ready);
      end
      tick();
    end
    $display("tx stall data=%h", bus.tx_data);
    bus.tx_ready = 1'b1;
    tick();
    bus.tx_ready = 1'b0;
    checks++;
    if (bus.tx_valid !== 1'b0 || bus.rx_ready !== 1'b1 || bus.puf_challenge !== 64'h0000_0000_0000_00A1) begin
      errors++;
      $display("FAIL b2b_after_hs: tx_valid=%b rx_ready=%b challenge=%h required 0/1/a1", bus.tx_valid, bus.rx_ready, bus.puf_challenge);
    end
    tick();
    bus.rx_valid = 1'b0;
    checks++;
    if (bus.puf_challenge !== 64'h0000_0000_0000_00B2 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: challenge=%h busy=%b required b2/1", bus.puf_challenge, bus.busy);
    end
    for (int i = 0; i < NEV; i++) do_eval(64'h0000_0000_0000_0B2B, 0);
    recv(64'h0000_0000_0000_0B2B, "b2b_second");
  endtask

  task automatic test_reset_mid();
    int h0;
    h0 = hs_cnt;
    send_word(64'hCAFE_0000_CAFE_0000);
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.tx_valid !== 1'b0 || bus.puf_start !== 1'b0 || bus.timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL midreset_flags: busy=%b tx_valid=%b puf_start=%b terr=%b required 0", bus.busy, bus.tx_valid, bus.puf_start, bus.timeout_err);
    end
    checks++;
    if (bus.puf_challenge !== '0 || bus.tx_data !== '0) begin
      errors++;
      $display("FAIL midreset_data: challenge=%h tx_data=%h required 0", bus.puf_challenge, bus.tx_data);
    end
    tick();
    rst_n = 1'b1;
    bus.puf_response = 64'h1111_2222_3333_4444;
    bus.puf_done     = 1'b1;
    repeat (2) tick();
    bus.puf_done     = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.tx_valid !== 1'b0 || bus.rx_ready !== 1'b1 || hs_cnt !== h0) begin
      errors++;
      $display("FAIL midreset_abort: busy=%b tx_valid=%b rx_ready=%b handshakes=%0d required 0/0/1/%0d", bus.busy, bus.tx_valid, bus.rx_ready, hs_cnt, h0);
    end
    send_word(64'hBEEF_0000_0000_BEEF);
    for (int i = 0; i < NEV; i++) do_eval(64'h7777_8888_9999_AAAA, 3);
    recv(64'h7777_8888_9999_AAAA, "after_midreset");
  endtask

`ifdef PUF_SEQ_MAJORITY_EN
  task automatic test_majority();
    int s0;
    s0 = start_cnt;
    send_word(64'h0000_0000_0000_0007);
    do_eval(64'hF0, 1);
    do_eval(64'hCC, 0);
    do_eval(64'hAA, 2);
    checks++;
    if (start_cnt - s0 !== 3) begin
      errors++;
      $display("FAIL majority_starts: got %0d required 3", start_cnt - s0);
    end
    recv(64'hE8, "majority");
  endtask
`endif

  initial begin
    bus.rx_data      = '0;
    bus.rx_valid     = 1'b0;
    bus.tx_ready     = 1'b0;
    bus.puf_done     = 1'b0;
    bus.puf_response = '0;
    test_reset();
    test_basic();
    test_latency();
    test_timeout();
    test_done_on_timeout();
    test_back_to_back();
    test_reset_mid();
`ifdef PUF_SEQ_MAJORITY_EN
    test_majority();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
